// File: rtl/text_video_gen.sv
// text_video_gen: text-mode VGA generator for the Cobra1 display path.
// The counters run at pixel rate; each screen position passes a 3-stage pipe:
//   stage 0: counters -> video RAM address (registered, synchronous RAM)
//   stage 1: character code -> font address, glyph/flags registered
//   stage 2: pixel bit select + colour mux, outputs registered
// Ports:
//   clk_pxl, rst          pixel clock, synchronous active-high reset
//   v_ram_a / v_ram_di    video RAM address out / code in (1-cycle latency)
//   v_font_a / v_font_di  font ROM address out / glyph byte in (combinational)
//   cursor_en/cursor_addr hardware cursor control (sampled at stage 0)
//   VGA_*                 colour, syncs, blank; VGA_SYNC_N tied low
//   frame_start           one-cycle pulse while the counters sit at (0,0)
module text_video_gen #(
    parameter int          COLS         = 32,
    parameter int          ROWS         = 24,
    parameter int          CHAR_H       = 8,
    parameter int          SCALE        = 2,
    parameter int          H_VISIBLE    = 640,
    parameter int          H_TOTAL      = 800,
    parameter int          H_SYNC_START = 656,
    parameter int          H_SYNC_END   = 752,
    parameter int          V_VISIBLE    = 480,
    parameter int          V_TOTAL      = 525,
    parameter int          V_SYNC_START = 490,
    parameter int          V_SYNC_END   = 492,
    parameter int          H_OFFSET     = 64,
    parameter int          V_OFFSET     = 48,
    parameter bit          HS_POL       = 1'b0,
    parameter bit          VS_POL       = 1'b0,
    parameter bit          INV_BIT7     = 1'b1,
    parameter int          BLINK_FRAMES = 16,
    parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB       = 24'h000000,
    parameter logic [23:0] BORDER_RGB   = 24'h000040,
    parameter int          VADDR_W      = 11
) (
    input  logic                      clk_pxl,
    input  logic                      rst,
    output logic [VADDR_W-1:0]        v_ram_a,
    input  logic [7:0]                v_ram_di,
    output logic [7+$clog2(CHAR_H):0] v_font_a,
    input  logic [7:0]                v_font_di,
    input  logic                      cursor_en,
    input  logic [VADDR_W-1:0]        cursor_addr,
    output logic [7:0]                VGA_R,
    output logic [7:0]                VGA_G,
    output logic [7:0]                VGA_B,
    output logic                      VGA_HS,
    output logic                      VGA_VS,
    output logic                      VGA_BLANK_N,
    output logic                      VGA_SYNC_N,
    output logic                      frame_start
);
    localparam int HW  = $clog2(H_TOTAL);
    localparam int VW  = $clog2(V_TOTAL);
    localparam int GW  = $clog2(CHAR_H);
    localparam int SCW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int CW  = $clog2(COLS + 1);
    localparam int FW  = $clog2(BLINK_FRAMES + 1);

    localparam logic [HW-1:0]  H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  H_VIS  = HW'(H_VISIBLE);
    localparam logic [HW-1:0]  H_SS   = HW'(H_SYNC_START);
    localparam logic [HW-1:0]  H_SE   = HW'(H_SYNC_END);
    localparam logic [HW-1:0]  H_T0   = HW'(H_OFFSET);
    localparam logic [HW-1:0]  H_T1   = HW'(H_OFFSET + COLS * 8 * SCALE);
    localparam logic [VW-1:0]  V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  V_VIS  = VW'(V_VISIBLE);
    localparam logic [VW-1:0]  V_SS   = VW'(V_SYNC_START);
    localparam logic [VW-1:0]  V_SE   = VW'(V_SYNC_END);
    localparam logic [VW-1:0]  V_T0   = VW'(V_OFFSET);
    localparam logic [VW-1:0]  V_T1   = VW'(V_OFFSET + ROWS * CHAR_H * SCALE);
    localparam logic [SCW-1:0] SC_LAST = SCW'(SCALE - 1);
    localparam logic [GW-1:0]  G_LAST  = GW'(CHAR_H - 1);
    localparam logic [FW-1:0]  F_LAST  = FW'(BLINK_FRAMES - 1);

    // Counters and sub-counters; the sub-counters always describe the
    // position held in hcnt_q/vcnt_q.
    logic [HW-1:0]      hcnt_q, hcnt_d;
    logic [VW-1:0]      vcnt_q, vcnt_d;
    logic [SCW-1:0]     hsc_q, hsc_d, vsc_q, vsc_d;
    logic [2:0]         hbit_q, hbit_d;
    logic [CW-1:0]      col_q, col_d;
    logic [GW-1:0]      gline_q, gline_d;
    logic [VADDR_W-1:0] row_base_q, row_base_d;
    logic [VADDR_W-1:0] v_ram_a_q, v_ram_a_d;
    logic               frame_start_q, frame_start_d;
    logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
    logic               blink_q, blink_d;

    // Stage 1 and stage 2 pipeline registers
    logic          s1_vis_q, s1_txt_q, s1_cur_q, s1_hs_q, s1_vs_q;
    logic [2:0]    s1_bit_q;
    logic [GW-1:0] s1_grow_q;
    logic          s2_vis_q, s2_txt_q, s2_inv_q, s2_hs_q, s2_vs_q;
    logic [2:0]    s2_bit_q;
    logic [7:0]    s2_glyph_q;
    logic [23:0]   rgb_q, rgb_d;
    logic          hs_q, vs_q, blank_q;

    logic h_txt, v_txt, line_end, vis0, txt0, cur0, hs0, vs0;
    logic [7:0] code_s;
    logic inv1, pix;

    always_comb begin
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        hsc_d         = hsc_q;
        hbit_d        = hbit_q;
        col_d         = col_q;
        vsc_d         = vsc_q;
        gline_d       = gline_q;
        row_base_d    = row_base_q;
        v_ram_a_d     = v_ram_a_q;
        frame_cnt_d   = frame_cnt_q;
        blink_d       = blink_q;

        h_txt    = (hcnt_q >= H_T0) && (hcnt_q < H_T1);
        v_txt    = (vcnt_q >= V_T0) && (vcnt_q < V_T1);
        line_end = (hcnt_q == H_LAST);

        hcnt_d = line_end ? '0 : hcnt_q + HW'(1);
        if (line_end)
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);

        // Horizontal: scale -> pixel-in-cell -> column
        if (hcnt_d == H_T0) begin
            hsc_d  = '0;
            hbit_d = '0;
            col_d  = '0;
        end else if (h_txt) begin
            if (hsc_q == SC_LAST) begin
                hsc_d = '0;
                if (hbit_q == 3'd7) begin
                    hbit_d = '0;
                    col_d  = col_q + CW'(1);
                end else begin
                    hbit_d = hbit_q + 3'd1;
                end
            end else begin
                hsc_d = hsc_q + SCW'(1);
            end
        end

        // Vertical: scale -> glyph row -> row base (cell index of column 0)
        if (line_end) begin
            if (vcnt_d == V_T0) begin
                vsc_d      = '0;
                gline_d    = '0;
                row_base_d = '0;
            end else if (v_txt) begin
                if (vsc_q == SC_LAST) begin
                    vsc_d = '0;
                    if (gline_q == G_LAST) begin
                        gline_d    = '0;
                        row_base_d = row_base_q + VADDR_W'(COLS);
                    end else begin
                        gline_d = gline_q + GW'(1);
                    end
                end else begin
                    vsc_d = vsc_q + SCW'(1);
                end
            end
        end

        // Address follows the next position; holds outside the text area
        if ((hcnt_d >= H_T0) && (hcnt_d < H_T1) && (vcnt_d >= V_T0) && (vcnt_d < V_T1))
            v_ram_a_d = row_base_d + VADDR_W'(col_d);

        frame_start_d = (hcnt_d == '0) && (vcnt_d == '0);

        if (frame_start_q) begin
            if (frame_cnt_q == F_LAST) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end

        // Stage 0 flags
        vis0 = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
        txt0 = h_txt && v_txt;
        cur0 = cursor_en && blink_q && (v_ram_a_q == cursor_addr);
        hs0  = ((hcnt_q >= H_SS) && (hcnt_q < H_SE)) ? HS_POL : ~HS_POL;
        vs0  = ((vcnt_q >= V_SS) && (vcnt_q < V_SE)) ? VS_POL : ~VS_POL;

        // Stage 1: font sees the code with the inverse bit stripped
        code_s = v_ram_di;
        if (INV_BIT7)
            code_s[7] = 1'b0;
        inv1 = (INV_BIT7 & v_ram_di[7]) ^ s1_cur_q;

        // Stage 2
        pix = s2_glyph_q[3'd7 - s2_bit_q] ^ s2_inv_q;
        if (!s2_vis_q)
            rgb_d = '0;
        else if (!s2_txt_q)
            rgb_d = BORDER_RGB;
        else
            rgb_d = pix ? FG_RGB : BG_RGB;
    end

    assign v_font_a = {code_s, s1_grow_q};

    always_ff @(posedge clk_pxl) begin
        if (rst) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            hsc_q         <= '0;
            hbit_q        <= '0;
            col_q         <= '0;
            vsc_q         <= '0;
            gline_q       <= '0;
            row_base_q    <= '0;
            v_ram_a_q     <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            blink_q       <= 1'b1;
            s1_vis_q      <= 1'b0;
            s1_txt_q      <= 1'b0;
            s1_cur_q      <= 1'b0;
            s1_hs_q       <= ~HS_POL;
            s1_vs_q       <= ~VS_POL;
            s1_bit_q      <= '0;
            s1_grow_q     <= '0;
            s2_vis_q      <= 1'b0;
            s2_txt_q      <= 1'b0;
            s2_inv_q      <= 1'b0;
            s2_hs_q       <= ~HS_POL;
            s2_vs_q       <= ~VS_POL;
            s2_bit_q      <= '0;
            s2_glyph_q    <= '0;
            rgb_q         <= '0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            blank_q       <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hsc_q         <= hsc_d;
            hbit_q        <= hbit_d;
            col_q         <= col_d;
            vsc_q         <= vsc_d;
            gline_q       <= gline_d;
            row_base_q    <= row_base_d;
            v_ram_a_q     <= v_ram_a_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_q       <= blink_d;
            s1_vis_q      <= vis0;
            s1_txt_q      <= txt0;
            s1_cur_q      <= cur0;
            s1_hs_q       <= hs0;
            s1_vs_q       <= vs0;
            s1_bit_q      <= hbit_q;
            s1_grow_q     <= gline_q;
            s2_vis_q      <= s1_vis_q;
            s2_txt_q      <= s1_txt_q;
            s2_inv_q      <= inv1;
            s2_hs_q       <= s1_hs_q;
            s2_vs_q       <= s1_vs_q;
            s2_bit_q      <= s1_bit_q;
            s2_glyph_q    <= v_font_di;
            rgb_q         <= rgb_d;
            hs_q          <= s2_hs_q;
            vs_q          <= s2_vs_q;
            blank_q       <= s2_vis_q;
        end
    end

    assign v_ram_a     = v_ram_a_q;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_q;
    assign VGA_SYNC_N  = 1'b0;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_text_video_gen.sv
// Bench for text_video_gen on a shrunken geometry (100x50 frame, 4x2 cells,
// SCALE 2, blink every 2 frames). Video RAM and font contents are random apart
// from a few cells used by the directed vectors; every cycle is checked
// against an arithmetic model of the screen.
module tb_text_video_gen;
    localparam int COLS = 4, ROWS = 2, CHAR_H = 8, SCALE = 2;
    localparam int HV = 80, HT = 100, HSS = 84, HSE = 92;
    localparam int VV = 44, VT = 50, VSS = 46, VSE = 48;
    localparam int HO = 8, VO = 4, BF = 2, VAW = 11;
    localparam int FRAME = HT * VT;
    localparam logic [23:0] FG = 24'hFFFFFF, BG = 24'h000000, BD = 24'h000040;
    localparam int F_RGB = 0, F_HS = 1, F_VS = 2, F_BLK = 3, F_FS = 4, F_VA = 5;

    logic           clk_pxl = 1'b0;
    logic           rst = 1'b1;
    logic [VAW-1:0] v_ram_a, cursor_addr;
    logic [7:0]     v_ram_di, v_font_di;
    logic [10:0]    v_font_a;
    logic           cursor_en;
    logic [7:0]     VGA_R, VGA_G, VGA_B;
    logic           VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;

    logic [7:0] vram [0:2047];
    logic [7:0] font [0:2047];

    always #5 clk_pxl = ~clk_pxl;
    always @(posedge clk_pxl) v_ram_di <= vram[v_ram_a];
    assign v_font_di = font[v_font_a];

    text_video_gen #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_H(CHAR_H), .SCALE(SCALE),
        .H_VISIBLE(HV), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_VISIBLE(VV), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
        .H_OFFSET(HO), .V_OFFSET(VO), .BLINK_FRAMES(BF), .VADDR_W(VAW)
    ) dut (
        .clk_pxl(clk_pxl), .rst(rst), .v_ram_a(v_ram_a), .v_ram_di(v_ram_di),
        .v_font_a(v_font_a), .v_font_di(v_font_di), .cursor_en(cursor_en),
        .cursor_addr(cursor_addr), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N), .frame_start(frame_start)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank;
    } pix_t;

    typedef struct {
        string name;
        int    n;
        int    fld;
        int    val;
    } vec_t;

    vec_t tbl[$];
    pix_t ring[4];
    int   n, errors, checks, model_va;

    function automatic void add(input string name, input int cyc, input int fld, input int val);
        vec_t v;
        v.name = name; v.n = cyc; v.fld = fld; v.val = val;
        tbl.push_back(v);
    endfunction

    function automatic bit in_text(input int h, input int v);
        return h >= HO && h < HO + COLS * 8 * SCALE && v >= VO && v < VO + ROWS * CHAR_H * SCALE;
    endfunction

    function automatic int cell_of(input int h, input int v);
        return ((v - VO) / (CHAR_H * SCALE)) * COLS + (h - HO) / (8 * SCALE);
    endfunction

    // Expected outputs for the screen position the counters hold at cycle c
    function automatic pix_t model_pix(input int c);
        pix_t p;
        int h, v, idx, bitn, gr;
        logic [7:0] code, g;
        logic inv, phase;
        h = c % HT;
        v = (c / HT) % VT;
        p.hs = !(h >= HSS && h < HSE);
        p.vs = !(v >= VSS && v < VSE);
        if (h >= HV || v >= VV) begin
            p.rgb = '0; p.blank = 1'b0;
        end else if (!in_text(h, v)) begin
            p.rgb = BD; p.blank = 1'b1;
        end else begin
            idx   = cell_of(h, v);
            bitn  = ((h - HO) / SCALE) % 8;
            gr    = ((v - VO) / SCALE) % CHAR_H;
            code  = vram[idx];
            phase = ((c / FRAME) / BF) % 2 == 0;
            inv   = code[7] ^ (cursor_en && phase && idx == int'(cursor_addr));
            g     = font[int'(code & 8'h7F) * CHAR_H + gr];
            p.rgb   = (g[7 - bitn] ^ inv) ? FG : BG;
            p.blank = 1'b1;
        end
        return p;
    endfunction

    function automatic int actual(input int fld);
        case (fld)
            F_RGB:   return int'({VGA_R, VGA_G, VGA_B});
            F_HS:    return int'(VGA_HS);
            F_VS:    return int'(VGA_VS);
            F_BLK:   return int'(VGA_BLANK_N);
            F_FS:    return int'(frame_start);
            default: return int'(v_ram_a);
        endcase
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s (n=%0d): got %0h, required %0h", name, n, got, want);
        end
    endtask

    // One cycle of model checking at cycle n (called at the falling edge)
    task automatic step(input bit use_tbl);
        pix_t e;
        logic fs_e;
        int h, v;
        h = n % HT;
        v = (n / HT) % VT;
        if (n < 3) e = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, blank: 1'b0};
        else       e = ring[(n + 1) % 4];
        if (in_text(h, v)) model_va = cell_of(h, v);
        fs_e = (n > 0) && (n % FRAME == 0);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} != e.rgb || VGA_HS != e.hs || VGA_VS != e.vs ||
            VGA_BLANK_N != e.blank || frame_start != fs_e || int'(v_ram_a) != model_va ||
            VGA_SYNC_N != 1'b0) begin
            errors++;
            $display("FAIL cycle n=%0d: got rgb=%h hs=%b vs=%b bl=%b fs=%b va=%0d sn=%b, required rgb=%h hs=%b vs=%b bl=%b fs=%b va=%0d sn=0",
                     n, {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start,
                     v_ram_a, VGA_SYNC_N, e.rgb, e.hs, e.vs, e.blank, fs_e, model_va);
        end
        ring[n % 4] = model_pix(n);
        if (use_tbl)
            foreach (tbl[i])
                if (tbl[i].n == n) check(tbl[i].name, actual(tbl[i].fld), tbl[i].val);
    endtask

    task automatic release_rst();
        rst = 1'b0;
        n = 0;
        model_va = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 2048; i++) begin
            vram[i] = 8'($urandom);
            font[i] = 8'($urandom);
        end
        vram[0] = 8'h41;
        vram[1] = 8'hC1;
        vram[5] = 8'h20;
        font[16'h41 * 8] = 8'h81;
        for (int r = 0; r < CHAR_H; r++) font[16'h20 * 8 + r] = 8'h00;
        cursor_en   = 1'b1;
        cursor_addr = 11'd5;

        add("rst_rgb", 0, F_RGB, 0);      add("rst_blank", 0, F_BLK, 0);
        add("rst_hs", 0, F_HS, 1);        add("rst_vs", 0, F_VS, 1);
        add("rst_fs", 0, F_FS, 0);        add("rst_va", 0, F_VA, 0);
        add("hs_pre", 86, F_HS, 1);       add("hs_first", 87, F_HS, 0);
        add("hs_last", 94, F_HS, 0);      add("hs_post", 95, F_HS, 1);
        add("hs_next", 187, F_HS, 0);
        add("vs_pre", 4602, F_VS, 1);     add("vs_first", 4603, F_VS, 0);
        add("vs_last", 4802, F_VS, 0);    add("vs_post", 4803, F_VS, 1);
        add("fs_pre", 4999, F_FS, 0);     add("fs", 5000, F_FS, 1);
        add("fs_post", 5001, F_FS, 0);    add("fs2", 10000, F_FS, 1);
        add("va_c0", 408, F_VA, 0);       add("va_c1", 424, F_VA, 1);
        add("va_c3", 456, F_VA, 3);       add("va_r1", 2008, F_VA, 4);
        add("va_r1e", 2056, F_VA, 7);     add("va_hold", 2080, F_VA, 7);
        add("va_hold2", 2099, F_VA, 7);
        add("g_fg0", 411, F_RGB, FG);     add("g_fg1", 412, F_RGB, FG);
        add("g_bg", 413, F_RGB, BG);      add("g_bg2", 424, F_RGB, BG);
        add("g_fg7", 425, F_RGB, FG);     add("g_fg7b", 426, F_RGB, FG);
        add("border_l", 410, F_RGB, BD);  add("border_r", 482, F_RGB, BD);
        add("vis_r", 482, F_BLK, 1);      add("blank", 483, F_BLK, 0);
        add("blank_rgb", 483, F_RGB, 0);
        add("inv_bg", 427, F_RGB, BG);    add("inv_bg2", 428, F_RGB, BG);
        add("inv_fg", 429, F_RGB, FG);
        add("cur_f0", 2027, F_RGB, FG);   add("cur_f1", 7027, F_RGB, FG);
        add("cur_f2", 12027, F_RGB, BG);  add("cur_f3", 17027, F_RGB, BG);
        add("cur_f4", 22027, F_RGB, FG);

        // Run A: reset release, directed vectors plus full model check
        repeat (3) @(negedge clk_pxl);
        release_rst();
        step(1);
        while (n < 22100) begin
            @(negedge clk_pxl);
            n++;
            step(1);
        end

        // Run B: random cursor settings, then a mid-frame reset in a BG frame
        rst = 1'b1;
        repeat (2) @(negedge clk_pxl);
        release_rst();
        step(0);
        while (n < 17430) begin
            @(negedge clk_pxl);
            n++;
            if (n % 997 == 0) begin
                cursor_en   = 1'($urandom);
                cursor_addr = 11'($urandom_range(0, COLS * ROWS - 1));
            end
            step(0);
        end
        rst = 1'b1;
        @(negedge clk_pxl);
        check("mr_rgb", actual(F_RGB), 0);
        check("mr_blank", actual(F_BLK), 0);
        check("mr_hs", actual(F_HS), 1);
        check("mr_vs", actual(F_VS), 1);
        check("mr_fs", actual(F_FS), 0);
        check("mr_va", actual(F_VA), 0);
        cursor_en   = 1'b1;
        cursor_addr = 11'd5;
        release_rst();
        step(0);
        while (n < 2100) begin
            @(negedge clk_pxl);
            n++;
            step(0);
            if (n == 87)   check("mr_hs_first", actual(F_HS), 0);
            if (n == 2027) check("mr_blink", actual(F_RGB), FG);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
